// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use bubbles, memory-wait freeze, branch flush, EX forwarding selects.
// Latency: enables, flushes and forwarding selects are combinational from the current inputs and state.
// Backpressure: a pending data-memory access freezes every latch; load-use and RAW hazards hold PC and IF/ID.
module hazard_ctrl_unit #(
  parameter int LOAD_LATENCY = 1,
  parameter int FWD_EN       = 1,
  parameter int MEM_TIMEOUT  = 255,
  parameter int STAT_W       = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_uses_rt,
  input  logic [4:0]        ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic              ex_br_taken,
  input  logic [4:0]        mem_rd,
  input  logic              mem_regwrite,
  input  logic [4:0]        wb_rd,
  input  logic              wb_regwrite,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  output logic              pc_en,
  output logic              fd_en,
  output logic              dx_en,
  output logic              xm_en,
  output logic              mw_en,
  output logic              fd_flush,
  output logic              dx_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mem_timeout,
  output logic [STAT_W-1:0] stall_cycles
);

  localparam int CW = (LOAD_LATENCY > 1) ? $clog2(LOAD_LATENCY) : 1;
  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {RUN, LDSTALL} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [WW-1:0] wait_cnt;
  logic          mw, lu;

  // True when a writer's destination matches a source read in decode ($0 never matches).
  function automatic logic src_hit(input logic [4:0] rd, input logic [4:0] rs,
                                   input logic [4:0] rt, input logic uses_rt);
    return (rd != 5'd0) && ((rd == rs) || (uses_rt && (rd == rt)));
  endfunction

  // Forwarding select for one EX operand: the younger MEM result wins over WB.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic m_wr, input logic [4:0] m_rd,
                                         input logic w_wr, input logic [4:0] w_rd);
    if (m_wr && (m_rd != 5'd0) && (m_rd == src))      return 2'b01;
    else if (w_wr && (w_rd != 5'd0) && (w_rd == src)) return 2'b10;
    else                                              return 2'b00;
  endfunction

  // Hazard detection; without forwarding every older in-flight writer forces a stall.
  always_comb begin
    mw = dmem_req && !dmem_ready;
    if (FWD_EN != 0) begin
      lu = ex_memread && ex_regwrite && src_hit(ex_rd, id_rs, id_rt, id_uses_rt);
    end else begin
      lu = (ex_regwrite  && src_hit(ex_rd,  id_rs, id_rt, id_uses_rt)) ||
           (mem_regwrite && src_hit(mem_rd, id_rs, id_rt, id_uses_rt)) ||
           (wb_regwrite  && src_hit(wb_rd,  id_rs, id_rt, id_uses_rt));
    end
  end

  // Next state and latch controls, priority: memory wait > taken branch > load-use stall.
  always_comb begin
    pc_en     = 1'b1;
    fd_en     = 1'b1;
    dx_en     = 1'b1;
    xm_en     = 1'b1;
    mw_en     = 1'b1;
    fd_flush  = 1'b0;
    dx_flush  = 1'b0;
    state_nxt = state;
    cnt_nxt   = cnt;
    if (RST) begin
      state_nxt = RUN;
      cnt_nxt   = '0;
    end else if (mw) begin
      pc_en = 1'b0;
      fd_en = 1'b0;
      dx_en = 1'b0;
      xm_en = 1'b0;
      mw_en = 1'b0;
    end else if (ex_br_taken) begin
      fd_flush  = 1'b1;
      dx_flush  = 1'b1;
      state_nxt = RUN;
      cnt_nxt   = '0;
    end else if (state == LDSTALL) begin
      pc_en    = 1'b0;
      fd_en    = 1'b0;
      dx_flush = 1'b1;
      cnt_nxt  = cnt - CW'(1);
      if (cnt == CW'(1)) state_nxt = RUN;
    end else if (lu) begin
      pc_en    = 1'b0;
      fd_en    = 1'b0;
      dx_flush = 1'b1;
      if (LOAD_LATENCY > 1) begin
        state_nxt = LDSTALL;
        cnt_nxt   = CW'(LOAD_LATENCY - 1);
      end
    end
  end

  // Operand forwarding selects, tied off when forwarding is disabled.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!RST && (FWD_EN != 0)) begin
      fwd_a = fwd_sel(id_rs, mem_regwrite, mem_rd, wb_regwrite, wb_rd);
      fwd_b = fwd_sel(id_rt, mem_regwrite, mem_rd, wb_regwrite, wb_rd);
    end
  end

  // Stall FSM register.
  always_ff @(posedge CLK) begin
    state <= state_nxt;
    cnt   <= cnt_nxt;
  end

  // Memory-wait watchdog: saturating wait counter and sticky timeout flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else if (mw) begin
      if (wait_cnt != WW'(MEM_TIMEOUT)) wait_cnt <= wait_cnt + WW'(1);
      if (wait_cnt >= WW'(MEM_TIMEOUT - 1)) mem_timeout <= 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // Saturating count of cycles where the PC did not advance.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cycles <= '0;
    end else if (!pc_en && (stall_cycles != {STAT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit with three parameterisations sharing one stimulus.
// ctl vectors are {pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush}.
module tb_hazard_ctrl_unit;

  logic       CLK = 1'b0;
  logic       RST;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
  logic       id_uses_rt, ex_regwrite, ex_memread, ex_br_taken;
  logic       mem_regwrite, wb_regwrite, dmem_req, dmem_ready;

  logic [6:0]  ctl_a, ctl_b, ctl_c;
  logic [1:0]  fa_a, fb_a, fa_b, fb_b, fa_c, fb_c;
  logic        to_a, to_b, to_c;
  logic [15:0] st_a, st_b;
  logic [2:0]  st_c;

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] RUNV  = 7'b1111100;
  localparam logic [6:0] STALL = 7'b0011101;
  localparam logic [6:0] FRZ   = 7'b0000000;
  localparam logic [6:0] BRF   = 7'b1111111;

  always #10 CLK = ~CLK;

  // A: LOAD_LATENCY=1, forwarding on
  hazard_ctrl_unit #(.LOAD_LATENCY(1), .FWD_EN(1), .MEM_TIMEOUT(255), .STAT_W(16)) u_a (
    .CLK(CLK), .RST(RST), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_br_taken(ex_br_taken),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(ctl_a[6]), .fd_en(ctl_a[5]), .dx_en(ctl_a[4]), .xm_en(ctl_a[3]), .mw_en(ctl_a[2]),
    .fd_flush(ctl_a[1]), .dx_flush(ctl_a[0]), .fwd_a(fa_a), .fwd_b(fb_a),
    .mem_timeout(to_a), .stall_cycles(st_a));

  // B: LOAD_LATENCY=3, short memory timeout
  hazard_ctrl_unit #(.LOAD_LATENCY(3), .FWD_EN(1), .MEM_TIMEOUT(3), .STAT_W(16)) u_b (
    .CLK(CLK), .RST(RST), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_br_taken(ex_br_taken),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(ctl_b[6]), .fd_en(ctl_b[5]), .dx_en(ctl_b[4]), .xm_en(ctl_b[3]), .mw_en(ctl_b[2]),
    .fd_flush(ctl_b[1]), .dx_flush(ctl_b[0]), .fwd_a(fa_b), .fwd_b(fb_b),
    .mem_timeout(to_b), .stall_cycles(st_b));

  // C: forwarding off, 3-bit statistics counter to reach saturation
  hazard_ctrl_unit #(.LOAD_LATENCY(1), .FWD_EN(0), .MEM_TIMEOUT(255), .STAT_W(3)) u_c (
    .CLK(CLK), .RST(RST), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_br_taken(ex_br_taken),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(ctl_c[6]), .fd_en(ctl_c[5]), .dx_en(ctl_c[4]), .xm_en(ctl_c[3]), .mw_en(ctl_c[2]),
    .fd_flush(ctl_c[1]), .dx_flush(ctl_c[0]), .fwd_a(fa_c), .fwd_b(fb_c),
    .mem_timeout(to_c), .stall_cycles(st_c));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_rd = 0; ex_regwrite = 0; ex_memread = 0;
    ex_br_taken = 0; mem_rd = 0; mem_regwrite = 0; wb_rd = 0; wb_regwrite = 0;
    dmem_req = 0; dmem_ready = 0;
  endtask

  // LW $3 in EX, decode reads $3 as rs
  task automatic set_lu();
    ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd3; id_rs = 5'd3;
  endtask

  initial begin
    idle();
    RST = 1;
    set_lu();
    dmem_req = 1;
    #1;
    chk("rst_ctl_a", 32'(ctl_a), 32'(RUNV));
    chk("rst_ctl_b", 32'(ctl_b), 32'(RUNV));
    chk("rst_fwd_a", 32'(fa_a), 32'd0);
    step(); step();
    idle();
    RST = 0;
    #1;
    chk("rst_stat_a", 32'(st_a), 32'd0);
    chk("rst_to_b", 32'(to_b), 32'd0);

    // Load-use, latency 1 on A and C, latency 3 on B
    set_lu(); #1;
    chk("lu_ctl_a", 32'(ctl_a), 32'(STALL));
    chk("lu_ctl_b", 32'(ctl_b), 32'(STALL));
    chk("lu_ctl_c", 32'(ctl_c), 32'(STALL));
    step();
    idle(); #1;
    chk("lu1_done_a", 32'(ctl_a), 32'(RUNV));
    chk("lu1_stat_a", 32'(st_a), 32'd1);
    chk("lu3_s2_b", 32'(ctl_b), 32'(STALL));
    step();
    chk("lu3_s3_b", 32'(ctl_b), 32'(STALL));
    step();
    chk("lu3_done_b", 32'(ctl_b), 32'(RUNV));
    chk("lu3_stat_b", 32'(st_b), 32'd3);

    // $0 never matches; forwarding priority
    ex_memread = 1; ex_regwrite = 1; ex_rd = 0; id_rs = 0; #1;
    chk("zero_nostall", 32'(ctl_a), 32'(RUNV));
    mem_regwrite = 1; mem_rd = 5'd5; wb_regwrite = 1; wb_rd = 5'd5; id_rs = 5'd5; #1;
    chk("fwd_mem_wins", 32'(fa_a), 32'd1);
    chk("fwd_off_c", 32'(fa_c), 32'd0);
    chk("nofwd_stall_c", 32'(ctl_c), 32'(STALL));
    mem_regwrite = 0; id_rt = 5'd5; #1;
    chk("fwd_wb_a", 32'(fa_a), 32'd2);
    chk("fwd_wb_b", 32'(fb_a), 32'd2);
    idle(); step();

    // rt only counts when decode actually reads it
    ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd6; id_rt = 5'd6; id_rs = 5'd1; #1;
    chk("rt_unused", 32'(ctl_a), 32'(RUNV));
    id_uses_rt = 1; #1;
    chk("rt_used", 32'(ctl_a), 32'(STALL));
    idle(); ex_regwrite = 1; ex_rd = 5'd4; id_rs = 5'd4; #1;
    chk("alu_nostall_a", 32'(ctl_a), 32'(RUNV));
    chk("alu_stall_c", 32'(ctl_c), 32'(STALL));
    idle(); step();

    // Memory wait during B's LDSTALL: freeze, count frozen, timeout after 3 cycles
    set_lu(); #1; step();
    idle(); dmem_req = 1; #1;
    for (int i = 0; i < 4; i++) begin
      chk("mw_ctl_a", 32'(ctl_a), 32'(FRZ));
      chk("mw_ctl_b", 32'(ctl_b), 32'(FRZ));
      step();
      chk("mw_to_b", 32'(to_b), (i >= 2) ? 32'd1 : 32'd0);
    end
    chk("mw_to_a", 32'(to_a), 32'd0);
    dmem_req = 0; #1;
    chk("mw_resume_a", 32'(ctl_a), 32'(RUNV));
    chk("mw_resume_b1", 32'(ctl_b), 32'(STALL));
    step();
    chk("mw_resume_b2", 32'(ctl_b), 32'(STALL));
    step();
    chk("mw_done_b", 32'(ctl_b), 32'(RUNV));
    chk("mw_stat_b", 32'(st_b), 32'd10);
    chk("mw_stat_a", 32'(st_a), 32'd6);
    chk("mw_to_sticky", 32'(to_b), 32'd1);

    // Taken branch beats load-use
    set_lu(); ex_br_taken = 1; #1;
    chk("br_lu_a", 32'(ctl_a), 32'(BRF));
    chk("br_lu_b", 32'(ctl_b), 32'(BRF));
    step();
    idle(); #1;
    chk("br_nostall_a", 32'(st_a), 32'd6);
    // Branch aborts LDSTALL
    set_lu(); #1; step();
    idle(); ex_br_taken = 1; #1;
    chk("br_abort_b", 32'(ctl_b), 32'(BRF));
    step();
    idle(); #1;
    chk("br_abort_run_b", 32'(ctl_b), 32'(RUNV));
    chk("br_abort_stat_b", 32'(st_b), 32'd11);
    // Memory wait beats branch
    ex_br_taken = 1; dmem_req = 1; #1;
    chk("mw_over_br", 32'(ctl_a), 32'(FRZ));
    dmem_ready = 1; #1;
    chk("ready_br", 32'(ctl_a), 32'(BRF));
    idle(); #1;

    // Reset in LDSTALL with cnt=2; C also saturates here
    set_lu(); #1; step();
    idle(); #1;
    chk("sat_c", 32'(st_c), 32'd7);
    chk("pre_rst_b", 32'(ctl_b), 32'(STALL));
    RST = 1; #1;
    chk("rst_mid_ctl_b", 32'(ctl_b), 32'(RUNV));
    step();
    RST = 0; #1;
    chk("rst_mid_stat_b", 32'(st_b), 32'd0);
    chk("rst_mid_to_b", 32'(to_b), 32'd0);
    chk("rst_mid_run_b", 32'(ctl_b), 32'(RUNV));
    step();
    chk("rst_mid_run2_b", 32'(ctl_b), 32'(RUNV));
    chk("rst_mid_stat2_b", 32'(st_b), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
